// File: rtl/ram_dc_param.sv
// ram_dc_param: cpu15 memory-stage data RAM plus memory-mapped I/O decoder.
// Ports: CLK_DC/RESET_N; RAM_AD_IN/RAM_RE/RAM_WE/RAM_IN/IO_IN in; RAM_AD_OUT/RAM_OUT/RAM_VALID/ADDR_ERR/IO_OUT out. Option: RAM_DC_IO_SYNC_EN.
module ram_dc_param #(
  parameter int DW          = 16,
  parameter int AW          = 8,
  parameter int RAM_DEPTH   = 8,
  parameter int IO_OUT_NUM  = 1,
  parameter int IO_OUT_BASE = 'h40,
  parameter int IO_IN_NUM   = 1,
  parameter int IO_IN_BASE  = 'h41
) (
  input  logic                     CLK_DC,
  input  logic                     RESET_N,
  input  logic [AW-1:0]            RAM_AD_IN,
  input  logic                     RAM_RE,
  input  logic                     RAM_WE,
  input  logic [DW-1:0]            RAM_IN,
  input  logic [IO_IN_NUM*DW-1:0]  IO_IN,
  output logic [AW-1:0]            RAM_AD_OUT,
  output logic [DW-1:0]            RAM_OUT,
  output logic                     RAM_VALID,
  output logic                     ADDR_ERR,
  output logic [IO_OUT_NUM*DW-1:0] IO_OUT
);

  localparam int ADDR_SPAN = 2 ** AW;
  localparam int OUT_END   = IO_OUT_BASE + IO_OUT_NUM;
  localparam int IN_END    = IO_IN_BASE + IO_IN_NUM;

  localparam bit OVL_RO =
    (0 < OUT_END) && (IO_OUT_BASE < RAM_DEPTH);
  localparam bit OVL_RI =
    (0 < IN_END) && (IO_IN_BASE < RAM_DEPTH);
  localparam bit OVL_OI =
    (IO_OUT_BASE < IN_END) && (IO_IN_BASE < OUT_END);
  localparam bit RANGE_BAD =
    (RAM_DEPTH > ADDR_SPAN) || (OUT_END > ADDR_SPAN) ||
    (IN_END > ADDR_SPAN) || (IO_IN_NUM < 1) ||
    (IO_OUT_NUM < 1);

  if (OVL_RO || OVL_RI || OVL_OI || RANGE_BAD) begin : g_cfg_err
    $error("ram_dc_param: address windows overlap or exceed space");
  end

  logic [DW-1:0] mem [RAM_DEPTH];

  logic [IO_IN_NUM*DW-1:0] io_in_v;

`ifdef RAM_DC_IO_SYNC_EN
  logic [IO_IN_NUM*DW-1:0] io_s1;
  logic [IO_IN_NUM*DW-1:0] io_s2;

  always_ff @(posedge CLK_DC or negedge RESET_N) begin
    if (!RESET_N) begin
      io_s1 <= '0;
      io_s2 <= '0;
    end else begin
      io_s1 <= IO_IN;
      io_s2 <= io_s1;
    end
  end

  assign io_in_v = io_s2;
`else
  assign io_in_v = IO_IN;
`endif

  int            addr;
  logic          hit_ram;
  logic          hit_out;
  logic          hit_in;
  logic [DW-1:0] ram_rd;
  logic [DW-1:0] out_rd;
  logic [DW-1:0] in_rd;
  logic [DW-1:0] rd_data;
  logic          wr_ok;
  logic          err_nxt;

  assign addr = int'(RAM_AD_IN);

  always_comb begin
    hit_ram = 1'b0;
    hit_out = 1'b0;
    hit_in  = 1'b0;
    ram_rd  = '0;
    out_rd  = '0;
    in_rd   = '0;
    for (int k = 0; k < RAM_DEPTH; k++) begin
      if (addr == k) begin
        hit_ram = 1'b1;
        ram_rd  = mem[k];
      end
    end
    for (int k = 0; k < IO_OUT_NUM; k++) begin
      if (addr == IO_OUT_BASE + k) begin
        hit_out = 1'b1;
        out_rd  = IO_OUT[k*DW +: DW];
      end
    end
    for (int k = 0; k < IO_IN_NUM; k++) begin
      if (addr == IO_IN_BASE + k) begin
        hit_in = 1'b1;
        in_rd  = io_in_v[k*DW +: DW];
      end
    end
  end

  // Writable windows bypass write data to a same-cycle read.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      hit_ram: rd_data = RAM_WE ? RAM_IN : ram_rd;
      hit_out: rd_data = RAM_WE ? RAM_IN : out_rd;
      hit_in:  rd_data = in_rd;
      default: rd_data = '0;
    endcase
  end

  assign wr_ok = RAM_WE && (hit_ram || hit_out);

  // One pulse even when a bad read and bad write coincide.
  assign err_nxt =
    (RAM_WE && !wr_ok) ||
    (RAM_RE && !(hit_ram || hit_out || hit_in));

  always_ff @(posedge CLK_DC or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < RAM_DEPTH; k++) begin
        mem[k] <= '0;
      end
      IO_OUT     <= '0;
      RAM_OUT    <= '0;
      RAM_AD_OUT <= '0;
      RAM_VALID  <= 1'b0;
      ADDR_ERR   <= 1'b0;
    end else begin
      for (int k = 0; k < RAM_DEPTH; k++) begin
        if (RAM_WE && addr == k) begin
          mem[k] <= RAM_IN;
        end
      end
      for (int k = 0; k < IO_OUT_NUM; k++) begin
        if (RAM_WE && addr == IO_OUT_BASE + k) begin
          IO_OUT[k*DW +: DW] <= RAM_IN;
        end
      end
      if (RAM_RE) begin
        RAM_OUT    <= rd_data;
        RAM_AD_OUT <= RAM_AD_IN;
      end
      RAM_VALID <= RAM_RE;
      ADDR_ERR  <= err_nxt;
    end
  end

endmodule
